// File: rtl/spike_encoder.sv
// Rate encoder: turns a vector of signed values into per-channel positive and
// negative spike trains over a fixed window, using one first-order sigma-delta
// accumulator per channel.
module spike_encoder #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned VALUE_WIDTH = 8,
  parameter int unsigned WINDOW      = 16,
  parameter int unsigned CNT_WIDTH   = $clog2(WINDOW + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CHANNELS*VALUE_WIDTH-1:0] in_values,
  input  logic                            step,
  input  logic                            abort,
  output logic [CHANNELS-1:0]             positive_spike,
  output logic [CHANNELS-1:0]             negative_spike,
  output logic                            busy,
  output logic                            window_done,
  output logic [CNT_WIDTH-1:0]            step_count
);

  localparam int unsigned Msb = VALUE_WIDTH - 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                                state_q, state_d;
  logic [CHANNELS-1:0][VALUE_WIDTH-2:0]  mag_q, mag_d;
  logic [CHANNELS-1:0]                   sign_q, sign_d;
  logic [CHANNELS-1:0][VALUE_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]                  cnt_q, cnt_d;
  logic [CHANNELS-1:0]                   pos_q, pos_d;
  logic [CHANNELS-1:0]                   neg_q, neg_d;
  logic                                  done_q, done_d;

  logic [CHANNELS-1:0][VALUE_WIDTH-2:0]  in_mag;
  logic [CHANNELS-1:0]                   in_sign;
  logic [CHANNELS-1:0][VALUE_WIDTH-1:0]  sum;
  logic [CHANNELS-1:0]                   fire;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [VALUE_WIDTH-1:0] v;
    logic [VALUE_WIDTH-1:0] v_neg;
    assign v       = in_values[i*VALUE_WIDTH +: VALUE_WIDTH];
    assign v_neg   = ~v + 1'b1;
    assign in_sign[i] = v[Msb];
    // Most negative input has no positive counterpart; clamp to the largest magnitude.
    assign in_mag[i] = !v[Msb]              ? v[VALUE_WIDTH-2:0] :
                       (v[VALUE_WIDTH-2:0] == '0) ? '1 : v_neg[VALUE_WIDTH-2:0];
    // acc < T and mag < T, so the sum fits in VALUE_WIDTH bits; its MSB is sum >= T.
    assign sum[i]  = acc_q[i] + {1'b0, mag_q[i]};
    assign fire[i] = sum[i][Msb];
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mag_q   <= '0;
      sign_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  // Next-state: load in idle, one accumulator update per step in run.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pos_d   = '0;
    neg_d   = '0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mag_d   = in_mag;
          sign_d  = in_sign;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (step) begin
          for (int i = 0; i < CHANNELS; i++) begin
            acc_d[i] = {1'b0, sum[i][VALUE_WIDTH-2:0]};
          end
          pos_d = fire & ~sign_q;
          neg_d = fire & sign_q;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(WINDOW - 1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready       = (state_q == StIdle);
  assign busy           = (state_q == StRun);
  assign positive_spike = pos_q;
  assign negative_spike = neg_q;
  assign window_done    = done_q;
  assign step_count     = cnt_q;

endmodule

// File: tb/tb_spike_encoder.sv
// Bench for spike_encoder: directed scenarios plus random windows, checked each
// cycle against a closed-form rate model (spike on step k iff floor(k*m/T) rises).
module tb_spike_encoder;

  localparam int CH = 4;
  localparam int VW = 8;
  localparam int W  = 16;
  localparam int T  = 128;
  localparam int CW = $clog2(W + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [CH*VW-1:0] in_values;
  logic             step;
  logic             abort;
  logic [CH-1:0]    positive_spike;
  logic [CH-1:0]    negative_spike;
  logic             busy;
  logic             window_done;
  logic [CW-1:0]    step_count;

  spike_encoder #(.CHANNELS(CH), .VALUE_WIDTH(VW), .WINDOW(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_values     (in_values),
    .step          (step),
    .abort         (abort),
    .positive_spike(positive_spike),
    .negative_spike(negative_spike),
    .busy          (busy),
    .window_done   (window_done),
    .step_count    (step_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_run;
  int          m_cnt;
  int          m_mag [CH];
  bit          m_sgn [CH];
  logic [CH-1:0] m_pos, m_neg;
  bit          m_done;
  int          pos_tot [CH];
  int          neg_tot [CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " pos"}, 32'(positive_spike), 32'(m_pos));
    chk({tag, " neg"}, 32'(negative_spike), 32'(m_neg));
    chk({tag, " done"}, 32'(window_done), 32'(m_done));
    chk({tag, " busy"}, 32'(busy), 32'(m_run));
    chk({tag, " ready"}, 32'(in_ready), 32'(!m_run));
    chk({tag, " count"}, 32'(step_count), 32'(m_cnt));
    chk({tag, " overlap"}, 32'(positive_spike & negative_spike), 32'd0);
  endtask

  function automatic void model_reset();
    m_run = 0; m_cnt = 0; m_pos = '0; m_neg = '0; m_done = 0;
  endfunction

  // Load a packed value vector; waits for in_ready is implied by caller.
  task automatic load(input logic [CH*VW-1:0] vals);
    in_valid = 1'b1; in_values = vals;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < CH; i++) begin
      int v;
      v = int'($signed(vals[i*VW +: VW]));
      m_sgn[i] = (v < 0);
      m_mag[i] = (v == -T) ? T - 1 : (v < 0 ? -v : v);
      pos_tot[i] = 0; neg_tot[i] = 0;
    end
    m_run = 1; m_cnt = 0; m_pos = '0; m_neg = '0; m_done = 0;
    check_outputs("load");
  endtask

  // One clock with the given step/abort; in_valid may be driven only while running.
  task automatic cycle(input bit st, input bit ab, input bit iv);
    step = st; abort = ab;
    if (iv && m_run) begin in_valid = 1'b1; in_values = $urandom; end
    @(posedge clk); #1;
    step = 1'b0; abort = 1'b0; in_valid = 1'b0;
    m_pos = '0; m_neg = '0; m_done = 0;
    if (m_run && ab) begin
      m_run = 0; m_cnt = 0;
    end else if (m_run && st) begin
      int k;
      k = m_cnt + 1;
      for (int i = 0; i < CH; i++) begin
        bit f;
        f = (k * m_mag[i] / T) != ((k - 1) * m_mag[i] / T);
        m_pos[i] = f && !m_sgn[i];
        m_neg[i] = f && m_sgn[i];
      end
      m_cnt = k;
      if (k == W) begin m_done = 1; m_run = 0; end
    end
    check_outputs("cycle");
    for (int i = 0; i < CH; i++) begin
      pos_tot[i] += int'(positive_spike[i]);
      neg_tot[i] += int'(negative_spike[i]);
    end
    if (m_done) begin
      for (int i = 0; i < CH; i++) begin
        chk("total pos", 32'(pos_tot[i]), 32'(m_sgn[i] ? 0 : W * m_mag[i] / T));
        chk("total neg", 32'(neg_tot[i]), 32'(m_sgn[i] ? W * m_mag[i] / T : 0));
      end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_values = '0; step = 1'b0; abort = 1'b0;
    model_reset();

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    reset = 1'b1;
    cycle(1, 0, 0);

    // {127,64,0,-64}, 16 back-to-back steps.
    load({8'hC0, 8'h00, 8'h40, 8'h7F});
    for (int s = 0; s < W; s++) cycle(1, 0, 1);
    chk("s2 ch0 pos", 32'(pos_tot[0]), 32'd15);
    chk("s2 ch1 pos", 32'(pos_tot[1]), 32'd8);
    chk("s2 ch2 pos", 32'(pos_tot[2]), 32'd0);
    chk("s2 ch3 neg", 32'(neg_tot[3]), 32'd8);
    chk("s2 final count", 32'(step_count), 32'(W));

    // {-128,1,127,-1}.
    load({8'hFF, 8'h7F, 8'h01, 8'h80});
    for (int s = 0; s < W; s++) cycle(1, 0, 0);
    chk("s3 ch0 neg", 32'(neg_tot[0]), 32'd15);
    chk("s3 ch1 pos", 32'(pos_tot[1] + neg_tot[1]), 32'd0);
    chk("s3 ch2 pos", 32'(pos_tot[2]), 32'd15);
    chk("s3 ch3 any", 32'(pos_tot[3] + neg_tot[3]), 32'd0);

    // Step every third cycle.
    load({8'hC0, 8'h00, 8'h40, 8'h7F});
    for (int s = 0; s < W; s++) begin
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
    end
    chk("s4 ch1 pos", 32'(pos_tot[1]), 32'd8);
    chk("s4 ch3 neg", 32'(neg_tot[3]), 32'd8);

    // Abort with step high after 5 steps, then reload.
    load({8'hC0, 8'h00, 8'h40, 8'h7F});
    for (int s = 0; s < 5; s++) cycle(1, 0, 0);
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    load({8'h00, 8'h00, 8'h40, 8'h00});
    for (int s = 0; s < W; s++) cycle(1, 0, 0);

    // Asynchronous reset between edges mid-window.
    load({8'hC0, 8'h00, 8'h40, 8'h7F});
    for (int s = 0; s < 6; s++) cycle(1, 0, 0);
    step = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async reset");
    step = 1'b0;
    #1 reset = 1'b1;
    for (int s = 0; s < 4; s++) cycle(1, 0, 0);

    // Random windows with random step gaps, stray in_valid and occasional abort.
    for (int w = 0; w < 12; w++) begin
      int guard;
      load($urandom);
      guard = 0;
      while (m_run && guard < 200) begin
        cycle($urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0, $urandom_range(0, 1) == 1);
        guard++;
      end
      chk("window bound", 32'(m_run), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_encoder.md
Name: spike_encoder

Overview:
- Rate-codes a vector of signed input values (pixel or feature intensities) into per-channel positive and negative spike trains.
- The outputs drive the positive_spike / negative_spike inputs of a spiking_neuron layer.
- It is the transmitting end of the spike interface.
- One load produces a fixed window of time steps, using a first-order sigma-delta accumulator per channel.

Parameters:
- CHANNELS, 4: number of input values and spike lines per polarity.
- VALUE_WIDTH, 8: width of each signed two's-complement input value.
- WINDOW, 16: number of time steps per encoding window (>=2).
- CNT_WIDTH, $clog2(WINDOW+1): width of step_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_values is valid for loading.
- in_ready  output  1  encoder idle and able to accept a load.
- in_values  input  CHANNELS*VALUE_WIDTH  packed signed values; channel i = bits [i*VALUE_WIDTH +: VALUE_WIDTH].
- step  input  1  time-step strobe; one step per cycle where high.
- abort  input  1  synchronous cancel of the current window.
- positive_spike  output  CHANNELS  positive spike per channel, one-cycle pulse.
- negative_spike  output  CHANNELS  negative spike per channel, one-cycle pulse.
- busy  output  1  window in progress.
- window_done  output  1  one-cycle pulse, coincident with the final step's spike outputs.
- step_count  output  CNT_WIDTH  steps completed in the current window.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE. Outputs: positive_spike=0, negative_spike=0, busy=0, window_done=0, step_count=0, in_ready=1. All accumulators and latched values are cleared.
- States:
  - IDLE: in_ready=1, busy=0.
  - RUN: in_ready=0, busy=1.
- Load: the in_valid&&in_ready edge latches in_values, clears all accumulators and step_count, and moves to RUN. in_valid is ignored in RUN.
- Magnitude: m_i = |v_i|, held in VALUE_WIDTH-1 bits. v_i = -2^(VALUE_WIDTH-1) saturates to 2^(VALUE_WIDTH-1)-1. Sign s_i = MSB of v_i.
- Threshold: T = 2^(VALUE_WIDTH-1). Each accumulator is VALUE_WIDTH bits wide and unsigned.
- On each clk edge in RUN with step=1 and abort=0, for every channel:
  - sum = acc + m_i (no overflow, since acc < T and m_i < T).
  - If sum >= T: acc <= sum - T and fire=1. Otherwise acc <= sum and fire=0.
  - positive_spike[i] <= fire & ~s_i; negative_spike[i] <= fire & s_i.
  - step_count increments.
- Spike count over a window is exactly floor(WINDOW*m_i/T).
- The two polarities are never high together on one channel. Zero value: no spikes.
- Spike outputs are registered and high for exactly one cycle after the sampling edge. Any edge without a qualifying step clears them to 0. Back-to-back steps on consecutive cycles are legal.
- Step in IDLE is ignored and outputs stay 0.
- Final step (step_count==WINDOW-1 when step samples):
  - window_done <= 1 for one cycle, coincident with that step's spikes.
  - step_count <= WINDOW; state <= IDLE, so in_ready=1 in the same cycle as window_done.
  - A new load on the following edge is legal.
- Abort (RUN, abort=1 at an edge): state <= IDLE; spikes, window_done and step_count are cleared. abort has priority over step. abort in IDLE has no effect.
- An asynchronous reset mid-window returns all outputs to reset values immediately.
- Latency: 1 cycle from step to spike. A loaded value produces its first spike on step ceil(T/m_i).

Test Plan:
1. Reset held low for 3 cycles, then released -> all spike outputs 0, busy=0, step_count=0, in_ready=1.
2. Load {127,64,0,-64} (ch0..ch3), step high for 16 consecutive cycles -> positive_spike counts ch0=15, ch1=8 (on steps 2,4,...,16), ch2=0; negative_spike ch3=8. window_done is a single pulse on the 16th spike cycle, with in_ready=1 that cycle and step_count=16.
3. Load {-128,1,127,-1}, 16 steps -> ch0 negative=15 spikes, ch1 0 spikes, ch2 positive=15, ch3 0 spikes; no positive/negative overlap on any channel.
4. Load {64,...}, step every 3rd cycle -> same counts as scenario 2; each spike lasts exactly one cycle, the cycle after its step; outputs 0 in gap cycles.
5. Abort asserted with step high after 5 steps -> next cycle spikes=0, busy=0, in_ready=1, no window_done. Reloading 64 on ch1 gives its first spike on step 2 (accumulator cleared).
6. reset driven low asynchronously mid-window between clock edges -> outputs reach reset values without a clock edge; step pulses in IDLE afterwards produce no spikes.
